// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite word-memory responder: response codes,
// the full-word strobe value and the controller state encoding.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [3:0] FULL_STRB   = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WRESP,
    ST_READ,
    ST_RWAIT,
    ST_RRESP
  } state_e;

endpackage

// File: rtl/axi4_lite_wr_collect.sv
// AW/W holding registers with independent handshakes; a write becomes
// available once both halves are held or arriving this cycle.
module axi4_lite_wr_collect #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              accept_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] awaddr_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [3:0]        wstrb_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic              wr_rdy_o,
  output logic              wr_idle_o,
  output logic [ADDR_W-1:0] awaddr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [3:0]        wstrb_o
);

  logic              aw_full_q, w_full_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;

  assign awready_o = accept_i & ~aw_full_q;
  assign wready_o  = accept_i & ~w_full_q;
  // Counting the incoming beat lets the controller launch the write on the
  // same edge that completes the second handshake.
  assign wr_rdy_o  = (aw_full_q | awvalid_i) & (w_full_q | wvalid_i);
  assign wr_idle_o = ~(aw_full_q | awvalid_i | w_full_q | wvalid_i);
  assign awaddr_o  = awaddr_q;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = wstrb_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      if (clr_i) begin
        aw_full_q <= 1'b0;
      end else if (awvalid_i && awready_o) begin
        aw_full_q <= 1'b1;
        awaddr_q  <= awaddr_i;
      end
      if (clr_i) begin
        w_full_q <= 1'b0;
      end else if (wvalid_i && wready_o) begin
        w_full_q <= 1'b1;
        wdata_q  <= wdata_i;
        wstrb_q  <= wstrb_i;
      end
    end
  end

endmodule

// File: rtl/axi4_lite_mem_slave.sv
// AXI4-Lite single-beat responder driving a CE/RD/WR word memory, one transaction
// at a time. Define AXI_ADDR_CHECK_EN to reject out-of-range or unaligned addresses.
module axi4_lite_mem_slave
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int MEM_AW = 8
) (
  input  logic              iCLK,
  input  logic              iRSTN,
  input  logic [ADDR_W-1:0] iAWADDR,
  input  logic              iAWVALID,
  output logic              oAWREADY,
  input  logic [DATA_W-1:0] iWDATA,
  input  logic [3:0]        iWSTRB,
  input  logic              iWVALID,
  output logic              oWREADY,
  output logic [1:0]        oBRESP,
  output logic              oBVALID,
  input  logic              iBREADY,
  input  logic [ADDR_W-1:0] iARADDR,
  input  logic              iARVALID,
  output logic              oARREADY,
  output logic [DATA_W-1:0] oRDATA,
  output logic [1:0]        oRRESP,
  output logic              oRVALID,
  input  logic              iRREADY,
  output logic              oMEM_CE,
  output logic              oMEM_RD,
  output logic              oMEM_WR,
  output logic [31:0]       oMEM_ADDR,
  output logic [DATA_W-1:0] oMEM_WDATA,
  input  logic [DATA_W-1:0] iMEM_RDATA
);

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH * 4);

  state_e              state_q, state_d;
  logic                rst_done_q;
  logic                last_wr_q, last_wr_d;
  logic [MEM_AW-1:0]   ar_idx_q;
  logic                ar_ok_q;
  logic [1:0]          bresp_q, rresp_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                idle_rdy, ar_hs, wr_rdy, wr_idle;
  logic                aw_ok, ar_ok, wr_ok, mem_wr, mem_rd;
  logic [ADDR_W-1:0]   awaddr;
  logic [DATA_W-1:0]   wdata;
  logic [3:0]          wstrb;
  logic [MEM_AW-1:0]   aw_idx;

  assign idle_rdy = rst_done_q & (state_q == ST_IDLE);

  axi4_lite_wr_collect #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_collect (
    .clk_i     (iCLK),
    .rst_n_i   (iRSTN),
    .accept_i  (idle_rdy),
    .clr_i     (state_q == ST_WRITE),
    .awaddr_i  (iAWADDR),
    .awvalid_i (iAWVALID),
    .awready_o (oAWREADY),
    .wdata_i   (iWDATA),
    .wstrb_i   (iWSTRB),
    .wvalid_i  (iWVALID),
    .wready_o  (oWREADY),
    .wr_rdy_o  (wr_rdy),
    .wr_idle_o (wr_idle),
    .awaddr_o  (awaddr),
    .wdata_o   (wdata),
    .wstrb_o   (wstrb)
  );

`ifdef AXI_ADDR_CHECK_EN
  assign aw_ok = (awaddr < ADDR_LIMIT) && (awaddr[1:0] == 2'b00);
  assign ar_ok = (iARADDR < ADDR_LIMIT) && (iARADDR[1:0] == 2'b00);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{awaddr[ADDR_W-1:MEM_AW+2], awaddr[1:0],
                              iARADDR[ADDR_W-1:MEM_AW+2], iARADDR[1:0], ADDR_LIMIT};
  assign aw_ok = 1'b1;
  assign ar_ok = 1'b1;
`endif

  assign aw_idx = awaddr[MEM_AW+1:2];
  assign wr_ok  = (wstrb == FULL_STRB) & aw_ok;

  // A read is only admitted with no write in flight, or when it wins the
  // alternation against a complete write.
  assign oARREADY = idle_rdy & (wr_idle | (wr_rdy & last_wr_q));
  assign ar_hs    = iARVALID & oARREADY;

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (ar_hs) begin
          state_d = ST_READ;
          if (wr_rdy) last_wr_d = 1'b0;
        end else if (idle_rdy && wr_rdy) begin
          state_d = ST_WRITE;
          if (iARVALID) last_wr_d = 1'b1;
        end
      end
      ST_WRITE: state_d = ST_WRESP;
      ST_WRESP: if (iBREADY) state_d = ST_IDLE;
      ST_READ:  state_d = ST_RWAIT;
      ST_RWAIT: state_d = ST_RRESP;
      ST_RRESP: if (iRREADY) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      state_q    <= ST_IDLE;
      rst_done_q <= 1'b0;
      last_wr_q  <= 1'b0;
      ar_idx_q   <= '0;
      ar_ok_q    <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rst_done_q <= 1'b1;
      last_wr_q  <= last_wr_d;
      if (ar_hs) begin
        ar_idx_q <= iARADDR[MEM_AW+1:2];
        ar_ok_q  <= ar_ok;
      end
      if (state_q == ST_WRITE) bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      // The memory drives zero when not strobed, so the word is caught here.
      if (state_q == ST_RWAIT) begin
        rdata_q <= ar_ok_q ? iMEM_RDATA : '0;
        rresp_q <= ar_ok_q ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign mem_wr     = (state_q == ST_WRITE) & wr_ok;
  assign mem_rd     = (state_q == ST_READ) & ar_ok_q;
  assign oMEM_CE    = mem_wr | mem_rd;
  assign oMEM_WR    = mem_wr;
  assign oMEM_RD    = mem_rd;
  assign oMEM_ADDR  = mem_wr ? {{(32-MEM_AW){1'b0}}, aw_idx} :
                      mem_rd ? {{(32-MEM_AW){1'b0}}, ar_idx_q} : 32'd0;
  assign oMEM_WDATA = mem_wr ? wdata : '0;

  assign oBVALID = (state_q == ST_WRESP);
  assign oBRESP  = bresp_q;
  assign oRVALID = (state_q == ST_RRESP);
  assign oRRESP  = rresp_q;
  assign oRDATA  = rdata_q;

endmodule

// File: tb/tb_axi4_lite_mem_slave.sv
// Randomized bench for axi4_lite_mem_slave against a word-array reference model;
// honours AXI_ADDR_CHECK_EN in the same way as the design.
module tb_axi4_lite_mem_slave;

  logic        iCLK = 1'b0, iRSTN = 1'b0;
  logic [31:0] iAWADDR = '0, iWDATA = '0, iARADDR = '0, iMEM_RDATA;
  logic        iAWVALID = 1'b0, iWVALID = 1'b0, iBREADY = 1'b0, iARVALID = 1'b0, iRREADY = 1'b0;
  logic [3:0]  iWSTRB = '0;
  logic        oAWREADY, oWREADY, oBVALID, oARREADY, oRVALID, oMEM_CE, oMEM_RD, oMEM_WR;
  logic [1:0]  oBRESP, oRRESP;
  logic [31:0] oRDATA, oMEM_ADDR, oMEM_WDATA;

  always #5 iCLK = ~iCLK;

  axi4_lite_mem_slave dut (
    .iCLK(iCLK), .iRSTN(iRSTN),
    .iAWADDR(iAWADDR), .iAWVALID(iAWVALID), .oAWREADY(oAWREADY),
    .iWDATA(iWDATA), .iWSTRB(iWSTRB), .iWVALID(iWVALID), .oWREADY(oWREADY),
    .oBRESP(oBRESP), .oBVALID(oBVALID), .iBREADY(iBREADY),
    .iARADDR(iARADDR), .iARVALID(iARVALID), .oARREADY(oARREADY),
    .oRDATA(oRDATA), .oRRESP(oRRESP), .oRVALID(oRVALID), .iRREADY(iRREADY),
    .oMEM_CE(oMEM_CE), .oMEM_RD(oMEM_RD), .oMEM_WR(oMEM_WR),
    .oMEM_ADDR(oMEM_ADDR), .oMEM_WDATA(oMEM_WDATA), .iMEM_RDATA(iMEM_RDATA)
  );

`ifdef AXI_ADDR_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory device: registered read data, zero when not strobed.
  logic [31:0] mem [256];
  logic [31:0] mem_q = '0;
  assign iMEM_RDATA = mem_q;
  always @(posedge iCLK) begin
    if (oMEM_CE && oMEM_WR) mem[oMEM_ADDR[7:0]] <= oMEM_WDATA;
    mem_q <= (oMEM_CE && oMEM_RD) ? mem[oMEM_ADDR[7:0]] : 32'd0;
  end

  // Strobe monitor.
  int cyc_n = 0, ce_cnt = 0, wr_cnt = 0, rd_cnt = 0, wr_cyc = 0, rd_cyc = 0;
  logic [31:0] wr_addr = '0, wr_dat = '0, rd_addr = '0;
  always @(posedge iCLK) cyc_n++;
  always @(negedge iCLK) begin
    if (oMEM_CE) begin
      ce_cnt++;
      chk("rd_xor_wr", 32'(oMEM_RD ^ oMEM_WR), 32'd1);
      if (oMEM_WR) begin wr_cnt++; wr_cyc = cyc_n; wr_addr = oMEM_ADDR; wr_dat = oMEM_WDATA; end
      if (oMEM_RD) begin rd_cnt++; rd_cyc = cyc_n; rd_addr = oMEM_ADDR; end
    end
  end

  // Reference model.
  logic [31:0] ref_mem [256];

  function automatic bit addr_ok(input logic [31:0] a);
    return !CHECK || (a < 32'd1024 && a[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] widx(input logic [31:0] a);
    return {24'd0, a[9:2]};
  endfunction

  // Drives one write and/or one read; called and returns at posedge+1.
  task automatic run(input bit dw, input logic [31:0] wa, wd, input logic [3:0] ws,
                     input int aw_at, w_at, input bit dr, input logic [31:0] ra, input int ar_at,
                     input int bdly, rdly,
                     output logic [1:0] bresp, rresp, output logic [31:0] rdata,
                     output int b_lat, r_lat, output bit r_stable, output int hold_ce);
    bit aw_d, w_d, ar_d, b_d, r_d, hs_aw, hs_w, hs_ar;
    int aw_e, w_e, ar_e, b_first, r_first, bv, rv, ce0;
    aw_d = !dw; w_d = !dw; b_d = !dw; ar_d = !dr; r_d = !dr;
    aw_e = -1; w_e = -1; ar_e = -1; b_first = -1; r_first = -1; bv = 0; rv = 0; ce0 = 0;
    bresp = '0; rresp = '0; rdata = '0; b_lat = -1; r_lat = -1; r_stable = 1'b1; hold_ce = 0;
    for (int k = 0; k < 80 && !(b_d && r_d); k++) begin
      iAWADDR = wa; iWDATA = wd; iWSTRB = ws; iARADDR = ra;
      iAWVALID = !aw_d && k >= aw_at;
      iWVALID  = !w_d && k >= w_at;
      iARVALID = !ar_d && k >= ar_at;
      iBREADY  = oBVALID && bv >= bdly;
      iRREADY  = oRVALID && rv >= rdly;
      #1;
      hs_aw = iAWVALID && oAWREADY;
      hs_w  = iWVALID && oWREADY;
      hs_ar = iARVALID && oARREADY;
      if (oBVALID && !b_d) begin
        if (b_first < 0) begin b_first = k; bresp = oBRESP; end
        bv++;
        if (iBREADY) b_d = 1'b1;
      end
      if (oRVALID && !r_d) begin
        if (r_first < 0) begin
          r_first = k; rdata = oRDATA; rresp = oRRESP; ce0 = ce_cnt;
        end else if (oRDATA !== rdata || oRRESP !== rresp) begin
          r_stable = 1'b0;
        end
        rv++;
        if (iRREADY) begin r_d = 1'b1; hold_ce = ce_cnt - ce0; end
      end
      @(posedge iCLK); #1;
      if (hs_aw) begin aw_d = 1'b1; aw_e = k; end
      if (hs_w)  begin w_d = 1'b1; w_e = k; end
      if (hs_ar) begin ar_d = 1'b1; ar_e = k; end
    end
    iAWVALID = 0; iWVALID = 0; iARVALID = 0; iBREADY = 0; iRREADY = 0;
    chk("xfer_done", 32'(b_d && r_d), 32'd1);
    if (dw && b_first >= 0) b_lat = b_first - ((aw_e > w_e) ? aw_e : w_e);
    if (dr && r_first >= 0) r_lat = r_first - ar_e;
  endtask

  task automatic wr(input logic [31:0] a, d, input logic [3:0] s, input int aw_at, w_at, bdly);
    logic [1:0] br, rr; logic [31:0] rdv; int bl, rl, hc, n0; bit st, ok;
    n0 = wr_cnt;
    run(1'b1, a, d, s, aw_at, w_at, 1'b0, 32'd0, 0, bdly, 0, br, rr, rdv, bl, rl, st, hc);
    ok = (s == 4'hF) && addr_ok(a);
    chk("bresp", 32'(br), ok ? 32'd0 : 32'd2);
    chk("b_lat", 32'(bl), 32'd2);
    chk("wr_strobes", 32'(wr_cnt - n0), ok ? 32'd1 : 32'd0);
    if (ok) begin
      chk("wr_addr", wr_addr, widx(a));
      chk("wr_data", wr_dat, d);
      ref_mem[a[9:2]] = d;
    end
  endtask

  task automatic rd(input logic [31:0] a, input int ar_at, rdly);
    logic [1:0] br, rr; logic [31:0] rdv; int bl, rl, hc, n0; bit st, ok;
    n0 = rd_cnt;
    run(1'b0, 32'd0, 32'd0, 4'h0, 0, 0, 1'b1, a, ar_at, 0, rdly, br, rr, rdv, bl, rl, st, hc);
    ok = addr_ok(a);
    chk("rresp", 32'(rr), ok ? 32'd0 : 32'd2);
    chk("rdata", rdv, ok ? ref_mem[a[9:2]] : 32'd0);
    chk("r_lat", 32'(rl), 32'd3);
    chk("r_stable", 32'(st), 32'd1);
    chk("r_hold_ce", 32'(hc), 32'd0);
    chk("rd_strobes", 32'(rd_cnt - n0), ok ? 32'd1 : 32'd0);
    if (ok) chk("rd_addr", rd_addr, widx(a));
  endtask

  // Simultaneous write + read, different words; returns 1 when write strobed first.
  task automatic pair(input logic [31:0] wa, wd, ra, output bit w_first);
    logic [1:0] br, rr; logic [31:0] rdv; int bl, rl, hc, nw, nr; bit st;
    nw = wr_cnt; nr = rd_cnt;
    run(1'b1, wa, wd, 4'hF, 0, 0, 1'b1, ra, 0, 0, 0, br, rr, rdv, bl, rl, st, hc);
    chk("pair_bresp", 32'(br), 32'd0);
    chk("pair_rdata", rdv, ref_mem[ra[9:2]]);
    chk("pair_strobes", 32'((wr_cnt - nw) + (rd_cnt - nr)), 32'd2);
    ref_mem[wa[9:2]] = wd;
    w_first = wr_cyc < rd_cyc;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bit wf, got;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end

    // Reset state.
    @(posedge iCLK); #1;
    chk("rst_awready", 32'(oAWREADY), 0);
    chk("rst_arready", 32'(oARREADY), 0);
    chk("rst_outs", {oWREADY, oBVALID, oRVALID, oMEM_CE, oMEM_RD, oMEM_WR, oBRESP, oRRESP}, 0);
    chk("rst_rdata", oRDATA, 0);
    iRSTN = 1'b1; #1;
    chk("rdy_before_edge", 32'({oAWREADY, oWREADY, oARREADY}), 0);
    @(posedge iCLK); #1;
    chk("rdy_after_edge", 32'({oAWREADY, oWREADY, oARREADY}), 32'h7);

    // Directed cases.
    wr(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    wr(32'h20, 32'h12345678, 4'hF, 3, 0, 1);
    rd(32'h20, 0, 0);
    wr(32'h40, 32'hA5A50040, 4'hF, 0, 0, 0);
    pair(32'h30, 32'h0B0B0030, 32'h40, wf);
    chk("arb_write_first", 32'(wf), 1);
    pair(32'h44, 32'h0C0C0044, 32'h30, wf);
    chk("arb_read_first", 32'(wf), 0);
    rd(32'h10, 0, 5);
    wr(32'h50, 32'h55555555, 4'h3, 0, 0, 0);
    rd(32'h50, 0, 0);
    wr(32'h0, 32'hCAFEF00D, 4'hF, 1, 0, 0);
    rd(32'h400, 0, 0);
    wr(32'h404, 32'h77777777, 4'hF, 0, 0, 0);
    rd(32'h4, 0, 0);
    rd(32'h22, 1, 0);

    // Reset pulse while waiting on memory data.
    iARADDR = 32'h20; iARVALID = 1'b1; got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      #1; got = oARREADY;
      @(posedge iCLK); #1;
    end
    iARVALID = 1'b0;
    chk("rst_ar_hs", 32'(got), 1);
    @(posedge iCLK); #1;
    #2 iRSTN = 1'b0; #1;
    chk("arst_outs", {oMEM_CE, oMEM_RD, oMEM_WR, oBVALID, oRVALID, oAWREADY, oWREADY, oARREADY}, 0);
    chk("arst_rdata", oRDATA, 0);
    @(posedge iCLK); #1;
    chk("arst_hold_rvalid", 32'(oRVALID), 0);
    #2 iRSTN = 1'b1; #1;
    chk("arst_rdy_pre", 32'({oAWREADY, oARREADY}), 0);
    @(posedge iCLK); #1;
    chk("arst_rdy_post", 32'({oAWREADY, oARREADY}), 32'h3);
    rd(32'h20, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      a = {22'd0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 3) == 0) a = {22'd0, 8'($urandom), 2'b00};
      if ($urandom_range(0, 7) == 0) a = a + 32'h400;
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom);
      if ($urandom_range(0, 1) == 0)
        wr(a, $urandom, ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hF,
           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        rd(a, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
